pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised instruction-address generator for the fetch stage, next generation of the program counter. It holds the registered fetch PC, steps it by a fixed instruction size, and combinationally redirects on trap, jump or predicted return. Redirects arriving while the front end is stalled are held and applied on the first unstalled cycle instead of being lost. A small return-address stack (RAS) supplies predicted return targets.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 0, PC value after reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- trap_en  in  1  trap redirect request
- trap_address  in  XLEN  trap target
- jump_en  in  1  resolved jump/branch redirect
- jump_address  in  XLEN  jump target
- ret_en  in  1  predicted return; target is RAS top
- call_en  in  1  push call_link onto RAS
- call_link  in  XLEN  return address to push
- stall  in  1  hold PC and RAS; latch redirects
- pc  out  XLEN  fetch address this cycle (combinational)
- pc_src  out  3  selected source, encoding from package
- pending  out  1  a held redirect is waiting
- ras_empty  out  1  RAS count is zero

## Operation
- Source priority for pc: trap > jump > pending redirect > return (only if ret_en and RAS non-empty) > sequential (pc_reg).
- While reset is high, pc = RESET_VECTOR and pc_src = SEQ, regardless of other inputs.
- Not stalled: pc_reg <= pc + STEP. pending is cleared if it was selected or overridden by trap/jump.
- Stalled: pc_reg unchanged. If trap_en or jump_en, the higher-priority target is latched into pending_addr and pending is set. A later trap/jump during the same stall overwrites it; a jump never overwrites a pending trap.
- RAS: circular buffer, pointer plus saturating count.
  - Push on call_en & ~stall. When full, overwrite the oldest entry; count stays RAS_DEPTH.
  - Pop on ~stall & ret_en, only when RET is the selected source. A ret_en that loses to trap/jump/pending does not pop.
  - ret_en with RAS empty is ignored; source falls to sequential.
  - Pop and push in the same cycle: the top entry is replaced with call_link and count is unchanged. If empty, it is a plain push.
- Arithmetic is modulo 2^XLEN, so pc + STEP wraps to 0 at the top of the space. No alignment checking is performed.

## Timing
- Redirect-to-pc latency is 0 cycles (combinational). The following cycle's pc is target + STEP unless stalled.
- Held redirect appears on pc in the first cycle with stall low and no trap/jump.
- Reset values: pc_reg = RESET_VECTOR, pending = 0, pending_addr = 0, RAS count = 0, pointer = 0, entries = 0, ras_empty = 1.
- Reset asserted mid-stall or mid-redirect discards pending and the RAS contents. On the first cycle after release, pc = RESET_VECTOR.
- stall only freezes state; pc still reflects that cycle's selection, so the fetch address is visible while stalled.

## Structure
- pc_gen_pkg holds:
  - the pc_src enum: SRC_SEQ = 0, SRC_RET = 1, SRC_PEND = 2, SRC_JUMP = 3, SRC_TRAP = 4;
  - the RAS pointer-width function clog2(RAS_DEPTH).
- The sub-module return_address_stack (parameters XLEN, RAS_DEPTH; ports push, pop, push_data, top, empty, full) contains all RAS storage, pointer and count logic.
- pc_gen contains source selection, pc_reg, the pending register and pop qualification.

## Test plan
- Reset release with defaults, then 3 unstalled cycles -> pc = 0x0, 0x4, 0x8, 0xC.
- jump_en to 0x100 during stall, stall held 2 cycles, then released -> pc = 0x100 with pc_src = JUMP in the jump cycle. During the remaining stall cycle pc = pc_reg and pending = 1. On release pc = 0x100 (PEND), then 0x104.
- trap 0x80 and jump 0x200 in the same unstalled cycle -> pc = 0x80, pc_src = TRAP; next cycle pc = 0x84.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH = 4, then 5 rets -> pc = 0x50, 0x40, 0x30, 0x20; the 5th ret is SEQ with ras_empty = 1.
- Simultaneous call_en (link 0x44) and ret_en with top 0x20 -> pc = 0x20 this cycle; next ret yields 0x44 and the count is unchanged.
- XLEN = 8, RESET_VECTOR = 0xFC, STEP = 4 -> pc = 0xFC then 0x00. Reset asserted while pending = 1 -> pending = 0 and pc = 0xFC.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage PC generator.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_RET  = 3'd1,
    SRC_PEND = 3'd2,
    SRC_JUMP = 3'd3,
    SRC_TRAP = 3'd4
  } pc_src_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with saturating count; oldest entry is
// overwritten when full. Top of stack is read combinationally.
module return_address_stack
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entry_reg [RAS_DEPTH];
  logic [PW-1:0]   ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   top_idx;
  logic            do_pop;
  logic            replace;

  // ptr_reg names the next free slot, which is also the oldest slot when full.
  assign top_idx = ptr_reg - PW'(1);
  assign top     = entry_reg[top_idx];
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(RAS_DEPTH));
  assign do_pop  = pop & ~empty;
  assign replace = push & do_pop;

  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg[gi] <= '0;
        end else if (replace && top_idx == PW'(gi)) begin
          entry_reg[gi] <= push_data;
        end else if (push && !do_pop && ptr_reg == PW'(gi)) begin
          entry_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (replace) begin
      ptr_reg   <= ptr_reg;
      count_reg <= count_reg;
    end else if (push) begin
      ptr_reg <= ptr_reg + PW'(1);
      if (!full) count_reg <= count_reg + CW'(1);
    end else if (do_pop) begin
      ptr_reg   <= ptr_reg - PW'(1);
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: source selection, sequential PC register, held
// redirect across stalls, and return prediction from the RAS.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_address,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_address,
  input  logic            ret_en,
  input  logic            call_en,
  input  logic [XLEN-1:0] call_link,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      pc_src,
  output logic            pending,
  output logic            ras_empty
);

  logic [XLEN-1:0] pc_reg;
  logic            pending_reg;
  logic            pending_trap_reg;
  logic [XLEN-1:0] pending_addr_reg;
  logic [XLEN-1:0] ras_top;
  logic            ras_full;
  logic            ras_push;
  logic            ras_pop;
  pc_src_t         sel;

  // A held redirect only takes effect once the front end is moving again.
  always_comb begin
    sel = SRC_SEQ;
    pc  = pc_reg;
    if (reset) begin
      sel = SRC_SEQ;
      pc  = RESET_VECTOR;
    end else if (trap_en) begin
      sel = SRC_TRAP;
      pc  = trap_address;
    end else if (jump_en) begin
      sel = SRC_JUMP;
      pc  = jump_address;
    end else if (pending_reg && !stall) begin
      sel = SRC_PEND;
      pc  = pending_addr_reg;
    end else if (ret_en && !ras_empty) begin
      sel = SRC_RET;
      pc  = ras_top;
    end
  end

  assign pc_src   = sel;
  assign pending  = pending_reg;
  assign ras_push = ~reset & ~stall & call_en;
  assign ras_pop  = ~reset & ~stall & (sel == SRC_RET);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg           <= RESET_VECTOR;
      pending_reg      <= 1'b0;
      pending_trap_reg <= 1'b0;
      pending_addr_reg <= '0;
    end else if (stall) begin
      if (trap_en) begin
        pending_reg      <= 1'b1;
        pending_trap_reg <= 1'b1;
        pending_addr_reg <= trap_address;
      end else if (jump_en && !(pending_reg && pending_trap_reg)) begin
        pending_reg      <= 1'b1;
        pending_trap_reg <= 1'b0;
        pending_addr_reg <= jump_address;
      end
    end else begin
      pc_reg           <= pc + XLEN'(STEP);
      pending_reg      <= 1'b0;
      pending_trap_reg <= 1'b0;
    end
  end

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, an 8-bit wrap/reset sequence,
// and randomized cycles checked against a queue-based reference model.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, trap_en, jump_en, ret_en, call_en, stall;
  logic [31:0] trap_address, jump_address, call_link, pc;
  logic [2:0]  pc_src;
  logic        pending, ras_empty;

  logic        b_reset, b_stall, b_jump_en;
  logic [7:0]  b_pc;
  logic [2:0]  b_pc_src;
  logic        b_pending, b_ras_empty;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .trap_en(trap_en), .trap_address(trap_address),
    .jump_en(jump_en), .jump_address(jump_address), .ret_en(ret_en),
    .call_en(call_en), .call_link(call_link), .stall(stall),
    .pc(pc), .pc_src(pc_src), .pending(pending), .ras_empty(ras_empty)
  );

  pc_gen #(.XLEN(8), .RESET_VECTOR(8'hFC), .STEP(4), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .reset(b_reset), .trap_en(1'b0), .trap_address(8'h00),
    .jump_en(b_jump_en), .jump_address(8'h40), .ret_en(1'b0),
    .call_en(1'b0), .call_link(8'h00), .stall(b_stall),
    .pc(b_pc), .pc_src(b_pc_src), .pending(b_pending), .ras_empty(b_ras_empty)
  );

  // Reference model state
  logic [31:0] m_pc_reg, m_pend_addr;
  logic        m_pend, m_pend_trap;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_sel(output logic [31:0] p, output logic [2:0] s);
    p = m_pc_reg; s = 3'd0;
    if (reset)                         begin p = 32'h0;        s = 3'd0; end
    else if (trap_en)                  begin p = trap_address; s = 3'd4; end
    else if (jump_en)                  begin p = jump_address; s = 3'd3; end
    else if (m_pend && !stall)         begin p = m_pend_addr;  s = 3'd2; end
    else if (ret_en && m_ras.size()>0) begin p = m_ras[$];     s = 3'd1; end
  endfunction

  function automatic void model_update(input logic [31:0] p, input logic [2:0] s);
    if (reset) begin
      m_pc_reg = 32'h0; m_pend = 0; m_pend_trap = 0; m_pend_addr = 0;
      m_ras.delete();
    end else if (stall) begin
      if (trap_en) begin
        m_pend = 1; m_pend_trap = 1; m_pend_addr = trap_address;
      end else if (jump_en && !(m_pend && m_pend_trap)) begin
        m_pend = 1; m_pend_trap = 0; m_pend_addr = jump_address;
      end
    end else begin
      m_pc_reg = p + 32'd4;
      m_pend = 0; m_pend_trap = 0;
      if (s == 3'd1 && call_en) m_ras[m_ras.size()-1] = call_link;
      else if (s == 3'd1) void'(m_ras.pop_back());
      else if (call_en) begin
        m_ras.push_back(call_link);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input bit use_model);
    logic [31:0] ep;
    logic [2:0]  es;
    #2;
    model_sel(ep, es);
    if (use_model) begin
      chk("rand_pc", pc, ep);
      chk("rand_src", {29'd0, pc_src}, {29'd0, es});
      chk("rand_pending", {31'd0, pending}, {31'd0, m_pend});
      chk("rand_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      $display("rand t=%0t pc=%h src=%0d pend=%b empty=%b", $time, pc, pc_src, pending, ras_empty);
    end
    @(posedge clk);
    model_update(ep, es);
    @(negedge clk);
  endtask

  typedef struct {
    logic rst, stl, te; logic [31:0] ta;
    logic je; logic [31:0] ja;
    logic re, ce; logic [31:0] cl;
    logic [31:0] epc; logic [2:0] esrc; logic epend, eemp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic rst, stl, te, input logic [31:0] ta,
                              input logic je, input logic [31:0] ja,
                              input logic re, ce, input logic [31:0] cl,
                              input logic [31:0] epc, input logic [2:0] esrc,
                              input logic epend, eemp);
    vec_t v;
    v.rst = rst; v.stl = stl; v.te = te; v.ta = ta; v.je = je; v.ja = ja;
    v.re = re; v.ce = ce; v.cl = cl; v.epc = epc; v.esrc = esrc;
    v.epend = epend; v.eemp = eemp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, stl, te, input logic [31:0] ta,
                       input logic je, input logic [31:0] ja,
                       input logic re, ce, input logic [31:0] cl);
    reset = rst; stall = stl; trap_en = te; trap_address = ta;
    jump_en = je; jump_address = ja; ret_en = re; call_en = ce; call_link = cl;
  endtask

  initial begin
    //   rst stl te ta      je ja      re ce cl      | pc      src pend empty
    add(1, 0, 0, 0,       0, 0,       0, 0, 0,       32'h0,   0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h0,   0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h4,   0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h8,   0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'hC,   0, 0, 1);
    add(0, 1, 0, 0,       1, 32'h100, 0, 0, 0,       32'h100, 3, 0, 1);
    add(0, 1, 0, 0,       0, 0,       0, 0, 0,       32'h10,  0, 1, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h100, 2, 1, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h104, 0, 0, 1);
    add(0, 0, 1, 32'h80,  1, 32'h200, 0, 0, 0,       32'h80,  4, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h84,  0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h10,  32'h88,  0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h20,  32'h8C,  0, 0, 0);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h30,  32'h90,  0, 0, 0);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h40,  32'h94,  0, 0, 0);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h50,  32'h98,  0, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h50,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h40,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h30,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h20,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h24,  0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h10,  32'h28,  0, 0, 1);
    add(0, 0, 0, 0,       0, 0,       0, 1, 32'h20,  32'h2C,  0, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 1, 32'h44,  32'h20,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h44,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h10,  1, 0, 0);
    add(0, 0, 0, 0,       0, 0,       1, 0, 0,       32'h14,  0, 0, 1);
    add(0, 1, 1, 32'h300, 0, 0,       0, 0, 0,       32'h300, 4, 0, 1);
    add(0, 1, 0, 0,       1, 32'h400, 0, 0, 0,       32'h400, 3, 1, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h300, 2, 1, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h304, 0, 0, 1);
    add(0, 1, 0, 0,       1, 32'h500, 0, 0, 0,       32'h500, 3, 0, 1);
    add(1, 1, 0, 0,       0, 0,       0, 0, 0,       32'h0,   0, 1, 1);
    add(0, 0, 0, 0,       0, 0,       0, 0, 0,       32'h0,   0, 0, 1);

    b_reset = 1; b_stall = 0; b_jump_en = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(0);
    step(0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].te, vecs[i].ta, vecs[i].je,
            vecs[i].ja, vecs[i].re, vecs[i].ce, vecs[i].cl);
      #1;
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("vec%0d_src", i), {29'd0, pc_src}, {29'd0, vecs[i].esrc});
      chk($sformatf("vec%0d_pending", i), {31'd0, pending}, {31'd0, vecs[i].epend});
      chk($sformatf("vec%0d_empty", i), {31'd0, ras_empty}, {31'd0, vecs[i].eemp});
      $display("vec %0d pc=%h src=%0d pend=%b empty=%b", i, pc, pc_src, pending, ras_empty);
      #1;
      step(0);
    end

    // 8-bit instance: wrap past the top of the space, then reset while pending
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_reset = 0;
    #2;
    chk("x8_reset_pc", {24'd0, b_pc}, 32'hFC);
    chk("x8_reset_src", {29'd0, b_pc_src}, 32'd0);
    $display("x8 pc=%h src=%0d pend=%b", b_pc, b_pc_src, b_pending);
    @(negedge clk);
    #2;
    chk("x8_wrap_pc", {24'd0, b_pc}, 32'h00);
    $display("x8 pc=%h src=%0d pend=%b", b_pc, b_pc_src, b_pending);
    @(negedge clk);
    b_stall = 1; b_jump_en = 1;
    #2;
    chk("x8_jump_pc", {24'd0, b_pc}, 32'h40);
    chk("x8_jump_src", {29'd0, b_pc_src}, 32'd3);
    @(negedge clk);
    b_jump_en = 0;
    #2;
    chk("x8_pending_set", {31'd0, b_pending}, 32'd1);
    chk("x8_stall_pc", {24'd0, b_pc}, 32'h04);
    $display("x8 pc=%h src=%0d pend=%b", b_pc, b_pc_src, b_pending);
    @(negedge clk);
    b_reset = 1;
    @(negedge clk);
    b_reset = 0; b_stall = 0;
    #2;
    chk("x8_pending_clear", {31'd0, b_pending}, 32'd0);
    chk("x8_after_reset_pc", {24'd0, b_pc}, 32'hFC);
    chk("x8_after_reset_src", {29'd0, b_pc_src}, 32'd2 - 32'd2);
    $display("x8 pc=%h src=%0d pend=%b", b_pc, b_pc_src, b_pending);
    @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 6, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 1, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
